// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes rxd, samples each bit at mid-period and pushes good bytes to a FIFO.
// Frames with a bad stop bit, or arriving while the FIFO is full, are dropped and flagged (sticky).
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] wr_d,
    output logic       wr_en,
    input  logic       wr_full,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_M1 = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned FULL_M1 = CLKS_PER_BIT - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_idx;
    logic [7:0]             r_shift;
    logic [7:0]             r_wr_d;
    logic                   r_wr_en;
    logic                   r_busy;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic w_rx_s;
    logic w_fall;
    logic w_half_bit;
    logic w_full_bit;
    logic w_stop_sample;
    logic w_set_fe;
    logic w_set_ov;

    assign w_rx_s        = r_sync[SYNC_STAGES-1];
    assign w_fall        = r_rx_prev & ~w_rx_s;
    assign w_half_bit    = (r_cnt == CNT_W'(HALF_M1));
    assign w_full_bit    = (r_cnt == CNT_W'(FULL_M1));
    assign w_stop_sample = (r_state == S_STOP) && w_full_bit;
    assign w_set_fe      = w_stop_sample & ~w_rx_s;
    assign w_set_ov      = w_stop_sample & w_rx_s & wr_full;

    assign wr_d      = r_wr_d;
    assign wr_en     = r_wr_en;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Synchronizer resets to the idle (high) line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rx_prev <= w_rx_s;
        end
    end

    // Frame FSM with registered push strobe and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_wr_d  <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_half_bit) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_full_bit) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_full_bit) begin
                        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_rx_s && !wr_full) begin
                            r_wr_en <= 1'b1;
                            r_wr_d  <= r_shift;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_set_fe) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end
            if (w_set_ov) begin
                r_overrun <= 1'b1;
            end else if (err_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule
